// File: rtl/wta_layer_ctrl.sv
// ---------------------------------------------------------------------------
// wta_layer_ctrl
//
// Winner-take-all sequencer for one layer of thresholded neurons. Each input
// event waits for the synapse/adder pipeline to settle, scans every neuron
// output once, and reports the strongest non-zero neuron as a spike. Each
// neuron's threshold adapts afterwards: a winner's threshold is raised, and
// every threshold is lowered when nobody fired.
//
// Ports
//   i_clk          clock, everything on the rising edge
//   i_rst_n        synchronous active-low reset
//   i_event        one-cycle pulse, input event presented to the layer
//   i_neuronout    packed neuron outputs, neuron n at [n*p_vwidth +: p_vwidth]
//   i_learn_en     enables threshold adaptation in the UPDATE cycle
//   i_spike_ready  downstream accepts the pending spike
//   o_threshold    packed per-neuron thresholds, same packing as i_neuronout
//   o_spike_valid  winner spike pending
//   o_winner       winning neuron index, valid with o_spike_valid
//   o_busy         high in every state except IDLE
//   o_drop         pulse: an event arrived while busy and was discarded
// ---------------------------------------------------------------------------
module wta_layer_ctrl #(
    parameter int                  p_neurons = 4,
    parameter int                  p_vwidth  = 19,
    parameter int                  p_settle  = 2,
    parameter logic [p_vwidth-1:0] p_th_init = 19'd256,
    parameter logic [p_vwidth-1:0] p_th_inc  = 19'd16,
    parameter logic [p_vwidth-1:0] p_th_dec  = 19'd1,
    parameter logic [p_vwidth-1:0] p_th_min  = 19'd8,
    localparam int                 p_iw      = (p_neurons > 1) ? $clog2(p_neurons) : 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_event,
    input  logic [p_neurons*p_vwidth-1:0]   i_neuronout,
    input  logic                            i_learn_en,
    input  logic                            i_spike_ready,
    output logic [p_neurons*p_vwidth-1:0]   o_threshold,
    output logic                            o_spike_valid,
    output logic [p_iw-1:0]                 o_winner,
    output logic                            o_busy,
    output logic                            o_drop
);

    localparam int p_cw = (p_settle > 0) ? $clog2(p_settle + 1) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SCAN,
        ST_OUT,
        ST_UPDATE
    } state_e;

    state_e              state_q;
    logic [p_cw-1:0]     settle_cnt_q;
    logic [p_iw-1:0]     scan_idx_q;
    logic [p_iw-1:0]     winner_q;
    logic [p_vwidth-1:0] max_q;
    logic                found_q;
    logic                spike_valid_q;
    logic                busy_q;
    logic                drop_q;
    logic [p_vwidth-1:0] th_q [p_neurons];
    logic [p_vwidth-1:0] th_d [p_neurons];

    logic [p_vwidth-1:0] scan_val;
    logic                scan_gt;
    logic                found_d;
    logic                scan_last;

    // Raise a threshold, pinning at all-ones instead of wrapping.
    function automatic logic [p_vwidth-1:0] sat_inc(input logic [p_vwidth-1:0] v);
        logic [p_vwidth:0] s;
        s = {1'b0, v} + {1'b0, p_th_inc};
        return s[p_vwidth] ? {p_vwidth{1'b1}} : s[p_vwidth-1:0];
    endfunction

    // Lower a threshold but never below the floor; the compare is done one
    // bit wider so that floor+step cannot overflow.
    function automatic logic [p_vwidth-1:0] sat_dec(input logic [p_vwidth-1:0] v);
        logic [p_vwidth:0] lim;
        lim = {1'b0, p_th_min} + {1'b0, p_th_dec};
        return ({1'b0, v} >= lim) ? (v - p_th_dec) : p_th_min;
    endfunction

    // Live mux of the neuron currently being scanned. A loop compare keeps
    // indices beyond p_neurons-1 harmless for non-power-of-two layer sizes.
    always_comb begin
        scan_val = '0;
        for (int n = 0; n < p_neurons; n++) begin
            if (scan_idx_q == p_iw'(n)) begin
                scan_val = i_neuronout[n*p_vwidth +: p_vwidth];
            end
        end
    end

    // Strict compare against a running max that starts at zero: ties keep
    // the lower index and an all-zero neuron can never win.
    always_comb begin
        scan_gt   = (scan_val > max_q);
        found_d   = found_q | scan_gt;
        scan_last = (scan_idx_q == p_iw'(p_neurons - 1));
    end

    // Threshold adaptation, applied only on the edge leaving UPDATE.
    always_comb begin
        for (int n = 0; n < p_neurons; n++) begin
            th_d[n] = th_q[n];
            if (state_q == ST_UPDATE && i_learn_en) begin
                if (found_q) begin
                    if (winner_q == p_iw'(n)) begin
                        th_d[n] = sat_inc(th_q[n]);
                    end
                end else begin
                    th_d[n] = sat_dec(th_q[n]);
                end
            end
        end
    end

    // Sequencer and all registered outputs. Events arriving outside IDLE are
    // discarded and flagged through o_drop on the following cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= ST_IDLE;
            settle_cnt_q  <= '0;
            scan_idx_q    <= '0;
            winner_q      <= '0;
            max_q         <= '0;
            found_q       <= 1'b0;
            spike_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            drop_q        <= 1'b0;
            for (int n = 0; n < p_neurons; n++) begin
                th_q[n] <= p_th_init;
            end
        end else begin
            drop_q <= i_event && (state_q != ST_IDLE);
            for (int n = 0; n < p_neurons; n++) begin
                th_q[n] <= th_d[n];
            end

            case (state_q)
                ST_IDLE: begin
                    if (i_event) begin
                        state_q      <= ST_SETTLE;
                        settle_cnt_q <= '0;
                        busy_q       <= 1'b1;
                    end
                end

                ST_SETTLE: begin
                    if (settle_cnt_q == p_cw'(p_settle)) begin
                        state_q    <= ST_SCAN;
                        scan_idx_q <= '0;
                        max_q      <= '0;
                        found_q    <= 1'b0;
                        winner_q   <= '0;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + p_cw'(1);
                    end
                end

                ST_SCAN: begin
                    found_q <= found_d;
                    if (scan_gt) begin
                        max_q    <= scan_val;
                        winner_q <= scan_idx_q;
                    end
                    if (scan_last) begin
                        state_q       <= found_d ? ST_OUT : ST_UPDATE;
                        spike_valid_q <= found_d;
                    end else begin
                        scan_idx_q <= scan_idx_q + p_iw'(1);
                    end
                end

                ST_OUT: begin
                    if (i_spike_ready) begin
                        state_q       <= ST_UPDATE;
                        spike_valid_q <= 1'b0;
                    end
                end

                ST_UPDATE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end

                default: begin
                    state_q       <= ST_IDLE;
                    spike_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < p_neurons; g++) begin : g_th_out
        assign o_threshold[g*p_vwidth +: p_vwidth] = th_q[g];
    end

    assign o_spike_valid = spike_valid_q;
    assign o_winner      = winner_q;
    assign o_busy        = busy_q;
    assign o_drop        = drop_q;

endmodule

// File: tb/tb_wta_layer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wta_layer_ctrl
//
// Directed bench for wta_layer_ctrl with a 4-neuron layer. A second instance
// starts its thresholds just below full scale so saturation is reachable in a
// handful of wins. Both instances share clock and stimulus.
// ---------------------------------------------------------------------------
module tb_wta_layer_ctrl;

    localparam int VW = 19;
    localparam int NN = 4;

    logic              clk = 1'b0;
    logic              rstN;
    logic              eventIn;
    logic [NN*VW-1:0]  neuronOut;
    logic              learnEn;
    logic              spikeReady;
    logic [NN*VW-1:0]  threshold;
    logic              spikeValid;
    logic [1:0]        winner;
    logic              busy;
    logic              drop;
    logic [NN*VW-1:0]  thresholdSat;
    logic              spikeValidSat;
    logic [1:0]        winnerSat;
    logic              busySat;
    logic              dropSat;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wta_layer_ctrl #(
        .p_neurons(NN), .p_vwidth(VW), .p_settle(2)
    ) dut (
        .i_clk(clk), .i_rst_n(rstN), .i_event(eventIn), .i_neuronout(neuronOut),
        .i_learn_en(learnEn), .i_spike_ready(spikeReady), .o_threshold(threshold),
        .o_spike_valid(spikeValid), .o_winner(winner), .o_busy(busy), .o_drop(drop)
    );

    wta_layer_ctrl #(
        .p_neurons(NN), .p_vwidth(VW), .p_settle(2), .p_th_init(19'h7FFE8)
    ) dutSat (
        .i_clk(clk), .i_rst_n(rstN), .i_event(eventIn), .i_neuronout(neuronOut),
        .i_learn_en(learnEn), .i_spike_ready(spikeReady), .o_threshold(thresholdSat),
        .o_spike_valid(spikeValidSat), .o_winner(winnerSat), .o_busy(busySat), .o_drop(dropSat)
    );

    // Counts one comparison and reports it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [NN*VW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {VW'(d), VW'(c), VW'(b), VW'(a)};
    endfunction

    function automatic logic [31:0] thOf(input logic [NN*VW-1:0] v, input int n);
        return 32'(v[n*VW +: VW]);
    endfunction

    // Holds reset low over two edges; release happens with the next event.
    task automatic doReset();
        @(negedge clk);
        rstN    = 1'b0;
        eventIn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Presents one event (also releasing reset) and follows it until the
    // controller is idle again. firstEdge counts edges after the event edge.
    task automatic applyStimulus(input logic [NN*VW-1:0] vals, output int firstEdge,
                                 output int nValid, output int win);
        @(negedge clk);
        rstN      = 1'b1;
        neuronOut = vals;
        eventIn   = 1'b1;
        @(posedge clk);
        #1;
        eventIn   = 1'b0;
        firstEdge = -1;
        nValid    = 0;
        win       = -1;
        for (int e = 1; e <= 40; e++) begin
            @(posedge clk);
            #1;
            if (spikeValid) begin
                if (firstEdge < 0) firstEdge = e;
                win = int'(winner);
                nValid++;
            end
            if (!busy) break;
        end
        if (busy) checkOutput("idleTimeout", 32'(busy), 32'd0);
    endtask

    // Starts an event with ready low and returns once valid is seen.
    task automatic startHeldEvent(input logic [NN*VW-1:0] vals, output logic seen);
        @(negedge clk);
        rstN      = 1'b1;
        neuronOut = vals;
        eventIn   = 1'b1;
        @(posedge clk);
        #1;
        eventIn   = 1'b0;
        seen      = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            #1;
            if (spikeValid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int   fe, nv, w, total;
        logic seen;

        rstN       = 1'b0;
        eventIn    = 1'b0;
        neuronOut  = '0;
        learnEn    = 1'b1;
        spikeReady = 1'b1;

        // Reset state
        doReset();
        checkOutput("rstValid", 32'(spikeValid), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstDrop", 32'(drop), 32'd0);
        checkOutput("rstWinner", 32'(winner), 32'd0);
        for (int n = 0; n < NN; n++) checkOutput($sformatf("rstTh%0d", n), thOf(threshold, n), 32'd256);

        // Basic win on the first edge after reset release, latency 7
        applyStimulus(pack4(0, 300, 500, 0), fe, nv, w);
        checkOutput("t1Latency", 32'(fe), 32'd7);
        checkOutput("t1ValidCycles", 32'(nv), 32'd1);
        checkOutput("t1Winner", 32'(w), 32'd2);
        checkOutput("t1Th0", thOf(threshold, 0), 32'd256);
        checkOutput("t1Th1", thOf(threshold, 1), 32'd256);
        checkOutput("t1Th2", thOf(threshold, 2), 32'd272);
        checkOutput("t1Th3", thOf(threshold, 3), 32'd256);

        // Tie goes to the lowest index
        applyStimulus(pack4(400, 400, 0, 0), fe, nv, w);
        checkOutput("t2Winner", 32'(w), 32'd0);
        checkOutput("t2Th0", thOf(threshold, 0), 32'd272);
        checkOutput("t2Th1", thOf(threshold, 1), 32'd256);
        checkOutput("t2Th2", thOf(threshold, 2), 32'd272);

        // Back-pressure: valid/winner held, second event dropped
        spikeReady = 1'b0;
        startHeldEvent(pack4(0, 0, 90, 120), seen);
        checkOutput("t3ValidSeen", 32'(seen), 32'd1);
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("t3HoldValid%0d", c), 32'(spikeValid), 32'd1);
            checkOutput($sformatf("t3HoldWinner%0d", c), 32'(winner), 32'd3);
            if (c == 1) eventIn = 1'b1;
            if (c == 2) begin
                checkOutput("t3DropPulse", 32'(drop), 32'd1);
                eventIn = 1'b0;
            end
            if (c == 3) checkOutput("t3DropClear", 32'(drop), 32'd0);
            @(posedge clk);
            #1;
        end
        spikeReady = 1'b1;
        for (int e = 0; e < 10 && busy; e++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("t3Idle", 32'(busy), 32'd0);
        checkOutput("t3Th3", thOf(threshold, 3), 32'd272);
        total = 0;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk);
            #1;
            if (spikeValid) total++;
        end
        checkOutput("t3NoExtraSpike", 32'(total), 32'd0);

        // Learning disabled: spike still issued, thresholds untouched
        learnEn = 1'b0;
        applyStimulus(pack4(0, 0, 0, 50), fe, nv, w);
        checkOutput("t4Winner", 32'(w), 32'd3);
        checkOutput("t4Th3", thOf(threshold, 3), 32'd272);
        learnEn = 1'b1;

        // Reset while a spike is pending
        spikeReady = 1'b0;
        startHeldEvent(pack4(10, 0, 0, 0), seen);
        checkOutput("t5ValidSeen", 32'(seen), 32'd1);
        @(negedge clk);
        rstN = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("t5Valid", 32'(spikeValid), 32'd0);
        checkOutput("t5Busy", 32'(busy), 32'd0);
        checkOutput("t5Th0", thOf(threshold, 0), 32'd256);
        checkOutput("t5Th3", thOf(threshold, 3), 32'd256);
        @(negedge clk);
        rstN       = 1'b1;
        spikeReady = 1'b1;
        total = 0;
        for (int e = 0; e < 15; e++) begin
            @(posedge clk);
            #1;
            if (spikeValid) total++;
        end
        checkOutput("t5NoSpike", 32'(total), 32'd0);
        checkOutput("t5Th0After", thOf(threshold, 0), 32'd256);

        // No winner: thresholds decay by one per event down to the floor
        total = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(pack4(0, 0, 0, 0), fe, nv, w);
            total += nv;
        end
        checkOutput("t6NoValid", 32'(total), 32'd0);
        checkOutput("t6Th0at10", thOf(threshold, 0), 32'd246);
        checkOutput("t6Th3at10", thOf(threshold, 3), 32'd246);
        for (int i = 0; i < 238; i++) begin
            applyStimulus(pack4(0, 0, 0, 0), fe, nv, w);
        end
        checkOutput("t6Th0at248", thOf(threshold, 0), 32'd8);
        checkOutput("t6Th2at248", thOf(threshold, 2), 32'd8);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(pack4(0, 0, 0, 0), fe, nv, w);
        end
        checkOutput("t6Th1Floor", thOf(threshold, 1), 32'd8);

        // Saturation on the high-threshold instance
        doReset();
        checkOutput("t7SatInit", thOf(thresholdSat, 1), 32'h7FFE8);
        applyStimulus(pack4(0, 100, 0, 0), fe, nv, w);
        checkOutput("t7SatStep", thOf(thresholdSat, 1), 32'h7FFF8);
        checkOutput("t7SatOther", thOf(thresholdSat, 0), 32'h7FFE8);
        learnEn = 1'b0;
        applyStimulus(pack4(0, 100, 0, 0), fe, nv, w);
        checkOutput("t7SatNoLearn", thOf(thresholdSat, 1), 32'h7FFF8);
        learnEn = 1'b1;
        applyStimulus(pack4(0, 100, 0, 0), fe, nv, w);
        checkOutput("t7SatClamp", thOf(thresholdSat, 1), 32'h7FFFF);
        applyStimulus(pack4(0, 100, 0, 0), fe, nv, w);
        checkOutput("t7SatHold", thOf(thresholdSat, 1), 32'h7FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
